// File: rtl/alt_vipvfr131_common_genlock_timing.sv
// Output-side video timing generator: free-running h/v counters with registered sync/de/sof decode,
// optionally genlocked to a remote sof_in reference.
module alt_vipvfr131_common_genlock_timing #(
  parameter int unsigned H_WIDTH    = 14,
  parameter int unsigned V_WIDTH    = 13,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [H_WIDTH-1:0] h_total,
  input  logic [V_WIDTH-1:0] v_total,
  input  logic [H_WIDTH-1:0] h_active,
  input  logic [V_WIDTH-1:0] v_active,
  input  logic [H_WIDTH-1:0] h_sync_start,
  input  logic [H_WIDTH-1:0] h_sync_end,
  input  logic [V_WIDTH-1:0] v_sync_start,
  input  logic [V_WIDTH-1:0] v_sync_end,
  input  logic               genlock_enable,
  input  logic               sof_in,
  input  logic               sof_locked_in,
  input  logic [H_WIDTH-1:0] sof_sample,
  input  logic [V_WIDTH-1:0] sof_line,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic               sof_out,
  output logic               locked,
  output logic [H_WIDTH-1:0] h_count,
  output logic [V_WIDTH-1:0] v_count
);

  localparam logic [H_WIDTH-1:0] HOne    = H_WIDTH'(1);
  localparam logic [V_WIDTH-1:0] VOne    = V_WIDTH'(1);
  localparam logic [3:0]         LockCnt = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {StFreeRun, StAlign, StLocked} state_e;

  state_e               state_q, state_d;
  logic [3:0]           match_cnt_q, match_cnt_d;
  logic                 locked_q, locked_d;
  logic [H_WIDTH-1:0]   h_q, h_d;
  logic [V_WIDTH-1:0]   v_q, v_d;
  logic                 h_sync_q, h_sync_d;
  logic                 v_sync_q, v_sync_d;
  logic                 de_q, de_d;
  logic                 sof_out_q, sof_out_d;

  // '>=' so that a total reduced below the live count wraps on the next tick
  function automatic logic h_wraps(input logic [H_WIDTH-1:0] h, input logic [H_WIDTH-1:0] tot);
    return h >= (tot - HOne);
  endfunction

  function automatic logic [V_WIDTH-1:0] v_next(input logic [V_WIDTH-1:0] v,
                                                input logic [V_WIDTH-1:0] tot, input logic wrap);
    if (!wrap) return v;
    return (v >= (tot - VOne)) ? '0 : v + VOne;
  endfunction

  logic match;
  assign match = (h_q == sof_sample) && (v_q == sof_line);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    locked_d    = locked_q;
    h_d         = h_q;
    v_d         = v_q;
    h_sync_d    = h_sync_q;
    v_sync_d    = v_sync_q;
    de_d        = de_q;
    sof_out_d   = 1'b0;
    if (ce) begin
      h_d       = h_wraps(h_q, h_total) ? '0 : h_q + HOne;
      v_d       = v_next(v_q, v_total, h_wraps(h_q, h_total));
      de_d      = (h_q < h_active) && (v_q < v_active);
      h_sync_d  = (h_q >= h_sync_start) && (h_q < h_sync_end);
      v_sync_d  = (v_q >= v_sync_start) && (v_q < v_sync_end);
      sof_out_d = (h_q == '0) && (v_q == '0);
      if (!genlock_enable || !sof_locked_in) begin
        state_d     = StFreeRun;
        match_cnt_d = '0;
        locked_d    = 1'b0;
      end else begin
        unique case (state_q)
          StFreeRun: begin
            state_d     = StAlign;
            match_cnt_d = '0;
            locked_d    = 1'b0;
          end
          StAlign: begin
            if (sof_in) begin
              if (match) begin
                match_cnt_d = match_cnt_q + 4'd1;
              end else begin
                // A reload counts as the first aligned frame
                match_cnt_d = 4'd1;
                h_d = h_wraps(sof_sample, h_total) ? '0 : sof_sample + HOne;
                v_d = v_next(sof_line, v_total, h_wraps(sof_sample, h_total));
              end
              if (match_cnt_d >= LockCnt) begin
                state_d  = StLocked;
                locked_d = 1'b1;
              end
            end
          end
          StLocked: begin
            if (sof_in && !match) begin
              state_d     = StAlign;
              locked_d    = 1'b0;
              match_cnt_d = 4'd1;
              h_d = h_wraps(sof_sample, h_total) ? '0 : sof_sample + HOne;
              v_d = v_next(sof_line, v_total, h_wraps(sof_sample, h_total));
            end
          end
          default: begin
            state_d     = StFreeRun;
            match_cnt_d = '0;
            locked_d    = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StFreeRun;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      h_q         <= '0;
      v_q         <= '0;
      h_sync_q    <= 1'b0;
      v_sync_q    <= 1'b0;
      de_q        <= 1'b0;
      sof_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      locked_q    <= locked_d;
      h_q         <= h_d;
      v_q         <= v_d;
      h_sync_q    <= h_sync_d;
      v_sync_q    <= v_sync_d;
      de_q        <= de_d;
      sof_out_q   <= sof_out_d;
    end
  end

  assign h_sync  = h_sync_q;
  assign v_sync  = v_sync_q;
  assign de      = de_q;
  assign sof_out = sof_out_q;
  assign locked  = locked_q;
  assign h_count = h_q;
  assign v_count = v_q;

endmodule

// File: tb/tb_alt_vipvfr131_common_genlock_timing.sv
// Directed bench for the genlock timing generator: free run decode, ce hold, genlock, relock, drop,
// live total reduction and mid-frame reset.
module tb_alt_vipvfr131_common_genlock_timing;

  localparam int unsigned H_WIDTH = 14;
  localparam int unsigned V_WIDTH = 13;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  logic [H_WIDTH-1:0] h_total, h_active, h_sync_start, h_sync_end, sof_sample;
  logic [V_WIDTH-1:0] v_total, v_active, v_sync_start, v_sync_end, sof_line;
  logic               genlock_enable, sof_in, sof_locked_in;
  logic               h_sync, v_sync, de, sof_out, locked;
  logic [H_WIDTH-1:0] h_count;
  logic [V_WIDTH-1:0] v_count;

  int n_checks = 0;
  int n_fail   = 0;

  alt_vipvfr131_common_genlock_timing #(
    .H_WIDTH   (H_WIDTH),
    .V_WIDTH   (V_WIDTH),
    .LOCK_COUNT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ce            (ce),
    .h_total       (h_total),
    .v_total       (v_total),
    .h_active      (h_active),
    .v_active      (v_active),
    .h_sync_start  (h_sync_start),
    .h_sync_end    (h_sync_end),
    .v_sync_start  (v_sync_start),
    .v_sync_end    (v_sync_end),
    .genlock_enable(genlock_enable),
    .sof_in        (sof_in),
    .sof_locked_in (sof_locked_in),
    .sof_sample    (sof_sample),
    .sof_line      (sof_line),
    .h_sync        (h_sync),
    .v_sync        (v_sync),
    .de            (de),
    .sof_out       (sof_out),
    .locked        (locked),
    .h_count       (h_count),
    .v_count       (v_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    sof_in = 1'b1;
    tick();
    sof_in = 1'b0;
  endtask

  int de_sum, hs_sum, vs_sum, sof_sum;

  initial begin
    rst = 1'b0; ce = 1'b1;
    h_total = 10; v_total = 4; h_active = 8; v_active = 3;
    h_sync_start = 8; h_sync_end = 9; v_sync_start = 3; v_sync_end = 4;
    genlock_enable = 1'b0; sof_in = 1'b0; sof_locked_in = 1'b0;
    sof_sample = 3; sof_line = 1;
    tick(2);
    chk("rst_h", 32'(h_count), 0);
    chk("rst_v", 32'(v_count), 0);
    chk("rst_de", 32'(de), 0);
    chk("rst_sof", 32'(sof_out), 0);
    chk("rst_locked", 32'(locked), 0);

    // Free run: one full 40-tick frame of decoded outputs
    rst = 1'b1;
    de_sum = 0; hs_sum = 0; vs_sum = 0; sof_sum = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      de_sum += int'(de); hs_sum += int'(h_sync); vs_sum += int'(v_sync); sof_sum += int'(sof_out);
      if (i == 8) chk("hsync_after_h8", 32'(h_sync), 1);
    end
    chk("de_per_frame", 32'(de_sum), 24);
    chk("hsync_per_frame", 32'(hs_sum), 4);
    chk("vsync_per_frame", 32'(vs_sum), 10);
    chk("sof_per_frame", 32'(sof_sum), 1);
    chk("frame_wrap_h", 32'(h_count), 0);
    chk("frame_wrap_v", 32'(v_count), 0);
    tick();
    chk("sof_out_pulse", 32'(sof_out), 1);

    // ce=0 holds counters and de, forces sof_out low
    ce = 1'b0;
    tick();
    chk("ce0_sof", 32'(sof_out), 0);
    chk("ce0_de_hold", 32'(de), 1);
    chk("ce0_h_hold", 32'(h_count), 1);
    ce = 1'b1;

    // Genlock: first pulse at (7,0) reloads to successor of (3,1)
    genlock_enable = 1'b1; sof_locked_in = 1'b1;
    tick(6);
    chk("pre_pulse_h", 32'(h_count), 7);
    pulse();
    chk("reload_h", 32'(h_count), 4);
    chk("reload_v", 32'(v_count), 1);
    for (int p = 2; p <= 5; p++) begin
      tick(39);
      chk("aligned_h", 32'(h_count), 3);
      chk("aligned_v", 32'(v_count), 1);
      pulse();
      chk("lock_progress", 32'(locked), (p >= 4) ? 1 : 0);
    end

    // Reference shifted by one tick: unlock on the same edge and reload
    tick(40);
    chk("shift_pre_h", 32'(h_count), 4);
    pulse();
    chk("shift_unlock", 32'(locked), 0);
    chk("shift_reload_h", 32'(h_count), 4);
    for (int p = 2; p <= 4; p++) begin
      tick(39);
      pulse();
      chk("relock_progress", 32'(locked), (p == 4) ? 1 : 0);
    end

    // Drop the remote lock mid-frame: unlock without a counter jump
    tick(10);
    sof_locked_in = 1'b0;
    tick();
    chk("drop_locked", 32'(locked), 0);
    chk("drop_h", 32'(h_count), 5);
    chk("drop_v", 32'(v_count), 2);

    // Shrink h_total below the live count: wraps on the next tick
    tick(2);
    chk("pre_shrink_h", 32'(h_count), 7);
    h_total = 5;
    tick();
    chk("shrink_h", 32'(h_count), 0);
    chk("shrink_v", 32'(v_count), 3);
    tick();
    chk("pre_rst_vsync", 32'(v_sync), 1);

    rst = 1'b0;
    tick();
    chk("midrst_h", 32'(h_count), 0);
    chk("midrst_v", 32'(v_count), 0);
    chk("midrst_vsync", 32'(v_sync), 0);
    chk("midrst_de", 32'(de), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
